axis_inf_counter_sequencer: RTL and testbench
=============================================

Name: axis_inf_counter_sequencer

Overview:
Controller that sequences a free-running AXIS sample counter. It issues the one-cycle run pulse and then a programmed train of trigger pulses: an initial delay, then a fixed period, for a fixed count. Each trigger's timestamp, relative to the run pulse, goes out on an AXIS master for software readback. It sits between the config/status register bank and the counter's run_flag/trg_flag inputs.

Parameters:
CNTR_WIDTH, 32, width of delay, period and timestamp values
TRG_CNT_WIDTH, 16, width of the trigger-count configuration and internal trigger counter

Ports:
aclk  in  1  system clock, all logic on rising edge
areset  in  1  asynchronous, active-high reset
cfg_start  in  1  level; rising edge while IDLE starts a sequence
cfg_abort  in  1  level; forces return to IDLE
cfg_delay  in  CNTR_WIDTH  cycles from run pulse to first trigger
cfg_period  in  CNTR_WIDTH  cycles between triggers; 0 is treated as 1
cfg_num  in  TRG_CNT_WIDTH  number of triggers to issue
run_flag  out  1  one-cycle run pulse to the counter
trg_flag  out  1  one-cycle trigger pulse to the counter
busy  out  1  high in RUN, DELAY and PERIOD states
done  out  1  high in DONE state
sts_overrun  out  1  sticky; a timestamp was dropped
m_axis_tdata  out  CNTR_WIDTH  trigger timestamp
m_axis_tvalid  out  1  timestamp valid
m_axis_tready  in  1  downstream ready

Behaviour:
- Reset (async, areset=1): state IDLE; run_flag, trg_flag, busy, done, sts_overrun, m_axis_tvalid = 0; m_axis_tdata = 0; all counters = 0.
- cfg_delay, cfg_period and cfg_num are latched on the start edge. Later changes have no effect until the next start.
- IDLE: on a cfg_start rising edge (registered previous value 0, current 1), go to RUN.
- RUN: one cycle; run_flag=1; timestamp counter cleared to 0; next state DELAY. If cfg_num==0, next state is DONE instead and no trigger is issued.
- DELAY: the timestamp counter increments every cycle from the cycle after RUN.
  - The first trg_flag pulse occurs exactly cfg_delay+1 cycles after the run_flag cycle, so cfg_delay=0 puts the trigger on the cycle after RUN.
  - On the trigger cycle the state moves to PERIOD.
- PERIOD: subsequent trg_flag pulses come every max(cfg_period,1) cycles.
  - After the cfg_num-th pulse, the next state is DONE. trg_flag is never high in DONE.
- DONE: done=1; hold until cfg_start==0, then go to IDLE.
- cfg_abort=1 in any state: next state IDLE. trg_flag and run_flag are suppressed in that cycle. A pending m_axis word is kept. Abort has priority over start.
- Timestamp counter: wraps modulo 2^CNTR_WIDTH with no flag.
- Timestamp slot: one-entry output register.
  - On each trg_flag cycle, if the slot is empty or emptying this cycle (tvalid & tready), load the timestamp and set tvalid=1.
  - Otherwise drop the new value and set sts_overrun=1.
  - tdata holds stable while tvalid & ~tready.
  - sts_overrun clears only on areset or on the next start edge.
- trg_flag and run_flag are registered outputs (no combinational path from cfg_* to the flags).

Optional Feature:
TRG_EXT_EN
- Defined: adds input port ext_trg (1 bit, asynchronous), synchronised with two flops.
  - In PERIOD, triggers fire on the synchronised rising edge of ext_trg instead of the period timer, and cfg_period is ignored.
  - The first trigger is still timed by cfg_delay.
  - Synchronised edges seen in DELAY are ignored.
- Undefined: no ext_trg port; periodic triggering only.

Decomposition:
- Package axis_inf_counter_seq_pkg holds:
  - the state enum (IDLE, RUN, DELAY, PERIOD, DONE);
  - the constant PERIOD_MIN=1;
  - the default width constants.
- One sub-module, axis_ts_slot: the one-entry AXIS output register with overrun detection. Inputs load/data; outputs tdata/tvalid/overrun.
- The FSM, timers and trigger counter stay in the top module.

Test Plan:
- cfg_delay=3, cfg_period=5, cfg_num=3, tready=1, start edge at cycle 0 ->
  - run_flag at cycle 1;
  - trg_flag at cycles 5, 10, 15;
  - timestamps 3, 8, 13;
  - done=1 from cycle 16.
- cfg_num=0 -> run_flag pulse, no trg_flag, done one cycle after RUN, no AXIS output.
- cfg_period=0, cfg_num=4, cfg_delay=0 -> triggers on 4 consecutive cycles after RUN; timestamps 0, 1, 2, 3.
- tready=0 with cfg_num=2 -> first timestamp held in tdata; second dropped; sts_overrun=1; after tready=1 exactly one word transfers.
- cfg_abort asserted in PERIOD after the 1st trigger -> IDLE next cycle; no further trg_flag; new start edge runs normally and clears sts_overrun.
- areset pulsed mid-DELAY (asynchronous, between clock edges) -> all outputs 0 immediately; holding cfg_start high afterwards does not restart without a new edge.

Source files
------------

// File: rtl/axis_inf_counter_seq_pkg.sv
// axis_inf_counter_seq_pkg: shared state encoding and defaults for the counter sequencer.
package axis_inf_counter_seq_pkg;
    typedef enum logic [2:0] {IDLE, RUN, DELAY, PERIOD, DONE} seq_state_t;
    localparam int PERIOD_MIN        = 1;
    localparam int CNTR_WIDTH_DEF    = 32;
    localparam int TRG_CNT_WIDTH_DEF = 16;
endpackage

// File: rtl/axis_ts_slot.sv
// axis_ts_slot: one-entry AXIS timestamp register with sticky overrun on a dropped load.
module axis_ts_slot #(
    parameter int W = 32
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         clr_overrun,
    input  logic         tready,
    output logic [W-1:0] tdata,
    output logic         tvalid,
    output logic         overrun
);
    logic accept;
    assign accept = ~tvalid | tready;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tdata   <= '0;
            tvalid  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load && accept) begin
                tdata  <= data;
                tvalid <= 1'b1;
            end else if (tready) begin
                tvalid <= 1'b0;
            end
            if (load && !accept) overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end
endmodule

// File: rtl/axis_inf_counter_sequencer.sv
// axis_inf_counter_sequencer: run pulse plus delayed periodic trigger train with AXIS timestamps.
// Define TRG_EXT_EN to replace the period timer with a synchronised external trigger input.
module axis_inf_counter_sequencer
    import axis_inf_counter_seq_pkg::*;
#(
    parameter int CNTR_WIDTH    = CNTR_WIDTH_DEF,
    parameter int TRG_CNT_WIDTH = TRG_CNT_WIDTH_DEF
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cfg_start,
    input  logic                     cfg_abort,
    input  logic [CNTR_WIDTH-1:0]    cfg_delay,
    input  logic [CNTR_WIDTH-1:0]    cfg_period,
    input  logic [TRG_CNT_WIDTH-1:0] cfg_num,
`ifdef TRG_EXT_EN
    input  logic                     ext_trg,
`endif
    output logic                     run_flag,
    output logic                     trg_flag,
    output logic                     busy,
    output logic                     done,
    output logic                     sts_overrun,
    output logic [CNTR_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
);
    seq_state_t state, state_nxt;
    logic start_q, start_edge, go, last, trg_d;
    logic [CNTR_WIDTH-1:0] delay_q, period_q, per_eff, t, t_nxt, ts;
    logic [TRG_CNT_WIDTH-1:0] num_q, n;
    assign busy = state == RUN || state == DELAY || state == PERIOD;
    assign done = state == DONE;
`ifdef TRG_EXT_EN
    logic [2:0] ext_s;
    logic ext_rise;
    assign ext_rise = ext_s[1] & ~ext_s[2];
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) ext_s <= '0;
        else ext_s <= {ext_s[1:0], ext_trg};
    end
`endif
    always_comb begin
        start_edge = cfg_start & ~start_q;
        go         = state == IDLE && start_edge && !cfg_abort;
        per_eff    = period_q == '0 ? CNTR_WIDTH'(PERIOD_MIN) : period_q;
        last       = trg_flag && (n + 1'b1) == num_q;
        state_nxt  = state;
        t_nxt      = t;
        case (state)
            IDLE:   state_nxt = start_edge ? RUN : IDLE;
            RUN: begin
                state_nxt = num_q == '0 ? DONE : DELAY;
                t_nxt     = delay_q;
            end
            DELAY, PERIOD: begin
                t_nxt     = trg_flag ? per_eff - 1'b1 : t - 1'b1;
                state_nxt = trg_flag ? (last ? DONE : PERIOD) : state;
            end
            DONE:   state_nxt = cfg_start ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cfg_abort) state_nxt = IDLE;
        // t holds cycles left until the next trigger, so the flag is registered one cycle early
`ifdef TRG_EXT_EN
        trg_d = state_nxt == DELAY ? t_nxt == '0 :
                state_nxt == PERIOD ? state == PERIOD && ext_rise : 1'b0;
`else
        trg_d = (state_nxt == DELAY || state_nxt == PERIOD) && t_nxt == '0;
`endif
    end
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            start_q  <= 1'b1; // a start already high when reset lifts needs a fresh edge
            delay_q  <= '0;
            period_q <= '0;
            num_q    <= '0;
            t        <= '0;
            n        <= '0;
            ts       <= '0;
            run_flag <= 1'b0;
            trg_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            start_q  <= cfg_start;
            t        <= t_nxt;
            run_flag <= state_nxt == RUN;
            trg_flag <= trg_d;
            ts       <= state == RUN ? '0 : ts + CNTR_WIDTH'(busy);
            n        <= state == RUN ? '0 : n + TRG_CNT_WIDTH'(trg_flag);
            if (go) begin
                delay_q  <= cfg_delay;
                period_q <= cfg_period;
                num_q    <= cfg_num;
            end
        end
    end
    axis_ts_slot #(.W(CNTR_WIDTH)) u_slot (
        .aclk        (aclk),
        .areset      (areset),
        .load        (trg_flag),
        .data        (ts),
        .clr_overrun (go),
        .tready      (m_axis_tready),
        .tdata       (m_axis_tdata),
        .tvalid      (m_axis_tvalid),
        .overrun     (sts_overrun)
    );
endmodule

// File: tb/tb_axis_inf_counter_sequencer.sv
// tb_axis_inf_counter_sequencer: scoreboard bench; stimulus queues expected flag cycles and words.
module tb_axis_inf_counter_sequencer;
    logic aclk = 1'b0, areset = 1'b1, cfg_start = 1'b0, cfg_abort = 1'b0;
    logic [31:0] cfg_delay = '0, cfg_period = '0;
    logic [15:0] cfg_num = '0;
    logic run_flag, trg_flag, busy, done, sts_overrun, m_axis_tvalid;
    logic m_axis_tready = 1'b1;
    logic [31:0] m_axis_tdata;
`ifdef TRG_EXT_EN
    logic ext_trg = 1'b0;
`endif
    int cyc = 0, vectors = 0, errs = 0, s;
    int exp_run[$], exp_trg[$];
    logic [31:0] exp_data[$];

    axis_inf_counter_sequencer dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_delay     (cfg_delay),
        .cfg_period    (cfg_period),
        .cfg_num       (cfg_num),
`ifdef TRG_EXT_EN
        .ext_trg       (ext_trg),
`endif
        .run_flag      (run_flag),
        .trg_flag      (trg_flag),
        .busy          (busy),
        .done          (done),
        .sts_overrun   (sts_overrun),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a flag or an accepted word.
    always @(negedge aclk) begin
        if (run_flag) begin
            if (exp_run.size() == 0) chk("unexpected_run", cyc, -1);
            else chk("run_cycle", cyc, exp_run.pop_front());
        end
        if (trg_flag) begin
            if (exp_trg.size() == 0) chk("unexpected_trg", cyc, -1);
            else chk("trg_cycle", cyc, exp_trg.pop_front());
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_data.size() == 0) chk("unexpected_word", m_axis_tdata, -1);
            else chk("tdata", m_axis_tdata, exp_data.pop_front());
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic idle_gap();
        cfg_start = 1'b0;
        goto(cyc + 2);
    endtask

    task automatic start_seq(input int d, input int p, input int n, output int st);
        cfg_delay  = 32'(d);
        cfg_period = 32'(p);
        cfg_num    = 16'(n);
        cfg_start  = 1'b1;
        st = cyc;
        exp_run.push_back(st + 1);
    endtask

    initial begin
        goto(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {run_flag, trg_flag}, 0);
        chk("rst_axis", {m_axis_tvalid, sts_overrun}, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        areset = 1'b0;
        idle_gap();
        // basic train: delay 3, period 5, three triggers; cfg changes after start are ignored
        start_seq(3, 5, 3, s);
        foreach (exp_trg[i]) ;
        exp_trg.push_back(s + 5); exp_trg.push_back(s + 10); exp_trg.push_back(s + 15);
        exp_data.push_back(3); exp_data.push_back(8); exp_data.push_back(13);
        goto(s + 2);
        cfg_delay = 99; cfg_period = 1; cfg_num = 7;
        chk("t1_busy", busy, 1);
        goto(s + 15);
        chk("t1_done_early", done, 0);
        goto(s + 16);
        chk("t1_done", done, 1);
        goto(s + 20);
        chk("t1_done_hold", done, 1);
        idle_gap();
        chk("t1_idle", done, 0);
        // zero triggers
        start_seq(5, 5, 0, s);
        goto(s + 2);
        chk("t2_done", done, 1);
        chk("t2_tvalid", m_axis_tvalid, 0);
        goto(s + 10);
        idle_gap();
        // period 0 acts as 1: back-to-back triggers
        start_seq(0, 0, 4, s);
        for (int i = 0; i < 4; i++) begin
            exp_trg.push_back(s + 2 + i);
            exp_data.push_back(32'(i));
        end
        goto(s + 6);
        chk("t3_done", done, 1);
        idle_gap();
        // backpressure: second timestamp dropped, overrun set
        m_axis_tready = 1'b0;
        start_seq(1, 2, 2, s);
        exp_trg.push_back(s + 3); exp_trg.push_back(s + 5);
        exp_data.push_back(1);
        goto(s + 6);
        chk("t4_overrun", sts_overrun, 1);
        chk("t4_tvalid", m_axis_tvalid, 1);
        chk("t4_tdata_held", m_axis_tdata, 1);
        chk("t4_done", done, 1);
        idle_gap();
        m_axis_tready = 1'b1;
        goto(cyc + 3);
        chk("t4_drained", m_axis_tvalid, 0);
        chk("t4_overrun_sticky", sts_overrun, 1);
        // abort after first trigger; pending word kept; start stays high without restarting
        m_axis_tready = 1'b0;
        start_seq(1, 3, 3, s);
        exp_trg.push_back(s + 3);
        exp_data.push_back(1);
        goto(s + 1);
        chk("t5_overrun_cleared", sts_overrun, 0);
        goto(s + 4);
        cfg_abort = 1'b1;
        goto(s + 5);
        cfg_abort = 1'b0;
        chk("t5_abort_idle", busy, 0);
        chk("t5_pending_valid", m_axis_tvalid, 1);
        chk("t5_pending_data", m_axis_tdata, 1);
        goto(s + 14);
        chk("t5_no_restart", busy, 0);
        m_axis_tready = 1'b1;
        idle_gap();
        start_seq(0, 1, 1, s);
        exp_trg.push_back(s + 2);
        exp_data.push_back(0);
        goto(s + 3);
        chk("t5_rerun_done", done, 1);
        idle_gap();
        // async reset mid-delay; held start must not restart
        start_seq(20, 1, 1, s);
        goto(s + 5);
        chk("t6_busy_before", busy, 1);
        #2 areset = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_flags", {run_flag, trg_flag, done, m_axis_tvalid}, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        goto(cyc + 30);
        chk("t6_no_restart", busy, 0);
        chk("t6_no_done", done, 0);
        chk("sb_run_left", exp_run.size(), 0);
        chk("sb_trg_left", exp_trg.size(), 0);
        chk("sb_data_left", exp_data.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
